// File: rtl/shiftout_chain.sv
// Serial driver for 74HC595-style shift/latch chains: shifts a WIDTH-bit word
// out on serial_o/sclk_o, then pulses lclk_o and flags completion on done_o.
module shiftout_chain #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned CLK_DIV     = 1,
  parameter int unsigned MSB_FIRST   = 0,
  parameter int unsigned LCLK_CYCLES = 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             serial_o,
  output logic             sclk_o,
  output logic             lclk_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int unsigned BW      = $clog2(WIDTH + 1);
  localparam int unsigned DIV_MAX = (CLK_DIV > LCLK_CYCLES) ? CLK_DIV : LCLK_CYCLES;
  localparam int unsigned CW      = ($clog2(DIV_MAX) > 0) ? $clog2(DIV_MAX) : 1;

  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] LAT_LAST = CW'(LCLK_CYCLES - 1);
  localparam logic [BW-1:0] BIT_END  = BW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOW   = 2'd1,
    HIGH  = 2'd2,
    LATCH = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]    div_cnt_q, div_cnt_d;
  logic [CW-1:0]    lat_cnt_q, lat_cnt_d;
  logic             serial_q, serial_d;
  logic             sclk_q, sclk_d;
  logic             lclk_q, lclk_d;
  logic             done_q, done_d;
  logic             cur_bit;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      lat_cnt_q <= '0;
      serial_q  <= 1'b0;
      sclk_q    <= 1'b0;
      lclk_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
      lat_cnt_q <= lat_cnt_d;
      serial_q  <= serial_d;
      sclk_q    <= sclk_d;
      lclk_q    <= lclk_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    lat_cnt_d = lat_cnt_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (valid_i) begin
          shreg_d   = data_i;
          bit_cnt_d = '0;
          div_cnt_d = '0;
          state_d   = LOW;
        end
      end
      LOW: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          state_d   = HIGH;
        end else begin
          div_cnt_d = div_cnt_q + CW'(1);
        end
      end
      HIGH: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          shreg_d   = (MSB_FIRST != 0) ? (shreg_q << 1) : (shreg_q >> 1);
          bit_cnt_d = bit_cnt_q + BW'(1);
          if (bit_cnt_d == BIT_END) begin
            lat_cnt_d = '0;
            state_d   = LATCH;
          end else begin
            state_d = LOW;
          end
        end else begin
          div_cnt_d = div_cnt_q + CW'(1);
        end
      end
      LATCH: begin
        if (lat_cnt_q == LAT_LAST) begin
          lat_cnt_d = '0;
          done_d    = 1'b1;
          state_d   = IDLE;
        end else begin
          lat_cnt_d = lat_cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Pin outputs are registered from the next state so they line up with state_q.
    cur_bit  = (MSB_FIRST != 0) ? shreg_d[WIDTH-1] : shreg_d[0];
    sclk_d   = (state_d == HIGH);
    lclk_d   = (state_d == LATCH);
    serial_d = 1'b0;
    if (state_d == LOW) begin
      serial_d = cur_bit;
    end else if (state_d == HIGH) begin
      serial_d = serial_q;
    end
  end

  assign ready_o  = (state_q == IDLE);
  assign busy_o   = ~ready_o;
  assign serial_o = serial_q;
  assign sclk_o   = sclk_q;
  assign lclk_o   = lclk_q;
  assign done_o   = done_q;

endmodule

// File: tb/tb_shiftout_chain.sv
// Directed bench for shiftout_chain: three parameterisations share clock and reset.
module tb_shiftout_chain;

  logic        clk;
  logic        reset;
  logic [15:0] data   [3];
  logic        valid  [3];
  logic        ready  [3];
  logic        serial [3];
  logic        sclk   [3];
  logic        lclk   [3];
  logic        busy   [3];
  logic        done   [3];

  int tests;
  int fails;

  shiftout_chain u_def (
    .clk_i(clk), .reset_i(reset), .data_i(data[0]), .valid_i(valid[0]),
    .ready_o(ready[0]), .serial_o(serial[0]), .sclk_o(sclk[0]),
    .lclk_o(lclk[0]), .busy_o(busy[0]), .done_o(done[0])
  );

  shiftout_chain #(.MSB_FIRST(1)) u_msb (
    .clk_i(clk), .reset_i(reset), .data_i(data[1]), .valid_i(valid[1]),
    .ready_o(ready[1]), .serial_o(serial[1]), .sclk_o(sclk[1]),
    .lclk_o(lclk[1]), .busy_o(busy[1]), .done_o(done[1])
  );

  shiftout_chain #(.WIDTH(8), .CLK_DIV(3), .LCLK_CYCLES(2)) u_div (
    .clk_i(clk), .reset_i(reset), .data_i(data[2][7:0]), .valid_i(valid[2]),
    .ready_o(ready[2]), .serial_o(serial[2]), .sclk_o(sclk[2]),
    .lclk_o(lclk[2]), .busy_o(busy[2]), .done_o(done[2])
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] word_at(input int n);
    return 16'(n * 32'h1357 + 32'h0A0F);
  endfunction

  task automatic check_idle_outputs(input int inst, input string name);
    tests++;
    if (sclk[inst] !== 1'b0 || lclk[inst] !== 1'b0 || serial[inst] !== 1'b0 ||
        done[inst] !== 1'b0 || busy[inst] !== 1'b0 || ready[inst] !== 1'b1) begin
      fails++;
      $display("FAIL %s inst%0d got sclk=%b lclk=%b ser=%b done=%b busy=%b rdy=%b exp 0,0,0,0,0,1",
               name, inst, sclk[inst], lclk[inst], serial[inst], done[inst], busy[inst], ready[inst]);
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) check_idle_outputs(i, "reset");
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // One transfer on instance inst; seq[width-1] is the first bit expected on the wire.
  task automatic run_transfer(input int inst, input logic [15:0] d, input logic [15:0] seq,
                              input int width, input int cdiv, input int lcyc, input string name);
    int  shift_cycles;
    int  total;
    int  rises;
    logic prev;
    logic exp_sclk, exp_lclk, exp_done, exp_ready;
    shift_cycles = 2 * cdiv * width;
    total        = shift_cycles + lcyc + 2;
    rises        = 0;
    prev         = 1'b0;
    tests++;
    if (ready[inst] !== 1'b1) begin
      fails++;
      $display("FAIL %s ready_before_accept got %b exp 1", name, ready[inst]);
    end
    valid[inst] = 1'b1;
    data[inst]  = d;
    @(posedge clk);
    #1;
    valid[inst] = 1'b0;
    data[inst]  = ~d;
    for (int k = 1; k <= total; k++) begin
      exp_sclk  = (k <= shift_cycles) && ((((k - 1) / cdiv) % 2) == 1);
      exp_lclk  = (k > shift_cycles) && (k <= shift_cycles + lcyc);
      exp_done  = (k == shift_cycles + lcyc + 1);
      exp_ready = (k >= shift_cycles + lcyc + 1);
      tests++;
      if (sclk[inst] !== exp_sclk || lclk[inst] !== exp_lclk ||
          done[inst] !== exp_done || ready[inst] !== exp_ready) begin
        fails++;
        $display("FAIL %s cycle %0d got sclk=%b lclk=%b done=%b rdy=%b exp %b,%b,%b,%b",
                 name, k, sclk[inst], lclk[inst], done[inst], ready[inst],
                 exp_sclk, exp_lclk, exp_done, exp_ready);
      end
      if (k > shift_cycles) begin
        tests++;
        if (serial[inst] !== 1'b0) begin
          fails++;
          $display("FAIL %s serial_after_shift cycle %0d got %b exp 0", name, k, serial[inst]);
        end
      end
      if (sclk[inst] === 1'b1 && prev === 1'b0) begin
        if (rises < width) begin
          tests++;
          if (serial[inst] !== seq[width - 1 - rises]) begin
            fails++;
            $display("FAIL %s bit at rise %0d got %b exp %b", name, rises + 1,
                     serial[inst], seq[width - 1 - rises]);
          end
        end
        rises++;
      end
      prev = sclk[inst];
      @(posedge clk);
      #1;
    end
    tests++;
    if (rises != width) begin
      fails++;
      $display("FAIL %s rise_count got %0d exp %0d", name, rises, width);
    end
  endtask

  task automatic test_lsb_first();
    run_transfer(0, 16'hA5C3, 16'b1100_0011_1010_0101, 16, 1, 1, "lsb_first");
  endtask

  task automatic test_msb_first();
    run_transfer(1, 16'hA5C3, 16'b1010_0101_1100_0011, 16, 1, 1, "msb_first");
  endtask

  task automatic test_slow_div();
    run_transfer(2, 16'h0081, 16'h0081, 8, 3, 2, "slow_div");
  endtask

  task automatic test_back_to_back();
    logic [15:0] rx;
    int   nbits;
    int   xfer;
    logic prev;
    logic [15:0] exp_word;
    rx    = '0;
    nbits = 0;
    xfer  = 0;
    prev  = 1'b0;
    valid[0] = 1'b1;
    data[0]  = word_at(0);
    for (int n = 1; n <= 102; n++) begin
      @(posedge clk);
      #1;
      tests++;
      if (done[0] !== ((n % 34) == 0) || ready[0] !== ((n % 34) == 0)) begin
        fails++;
        $display("FAIL b2b cycle %0d got done=%b rdy=%b exp %b", n, done[0], ready[0],
                 ((n % 34) == 0));
      end
      if (sclk[0] === 1'b1 && prev === 1'b0) begin
        if (nbits < 16) rx[nbits] = serial[0];
        nbits++;
      end
      prev = sclk[0];
      if ((n % 34) == 0) begin
        exp_word = word_at(xfer * 34);
        tests++;
        if (rx !== exp_word || nbits != 16) begin
          fails++;
          $display("FAIL b2b word %0d got %h (%0d bits) exp %h (16 bits)", xfer, rx, nbits, exp_word);
        end
        rx    = '0;
        nbits = 0;
        xfer++;
      end
      data[0] = word_at(n);
      if (n == 102) valid[0] = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_abort();
    int   rises;
    logic prev;
    rises = 0;
    prev  = 1'b0;
    valid[0] = 1'b1;
    data[0]  = 16'hFFFF;
    @(posedge clk);
    #1;
    valid[0] = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (sclk[0] === 1'b1 && prev === 1'b0) rises++;
      prev = sclk[0];
      if (rises == 7) break;
      @(posedge clk);
      #1;
    end
    tests++;
    if (rises != 7) begin
      fails++;
      $display("FAIL abort reach_7th_rise got %0d exp 7", rises);
    end
    #2 reset = 1'b1;
    #1;
    check_idle_outputs(0, "abort_reset");
    @(negedge clk) reset = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      tests++;
      if (sclk[0] !== 1'b0 || lclk[0] !== 1'b0 || done[0] !== 1'b0 || ready[0] !== 1'b1) begin
        fails++;
        $display("FAIL abort_quiet cycle %0d got sclk=%b lclk=%b done=%b rdy=%b exp 0,0,0,1",
                 k, sclk[0], lclk[0], done[0], ready[0]);
      end
    end
    run_transfer(0, 16'h0001, 16'h8000, 16, 1, 1, "after_abort");
  endtask

  initial begin
    tests = 0;
    fails = 0;
    clk   = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      valid[i] = 1'b0;
      data[i]  = '0;
    end
    test_reset();
    test_lsb_first();
    test_msb_first();
    test_slow_div();
    test_back_to_back();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
